// File: rtl/cam_ctrl.sv
// Request sequencer in front of a 16-entry byte CAM: search, allocate-on-miss, respond.
// Optional CAM_CTRL_STATS_EN adds saturating hit/miss/evict counters.
module cam_ctrl #(
  parameter int unsigned NB_MEM = 16,
  parameter int unsigned AW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [7:0]    req_data,
  input  logic          req_alloc,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [AW-1:0] rsp_index,
  output logic          rsp_evict,
  output logic          cam_enable,
  output logic          cam_write,
  output logic [AW-1:0] cam_addr,
  output logic [7:0]    cam_data,
  input  logic [AW-1:0] cam_out,
  input  logic          cam_found
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]   stat_hits,
  output logic [15:0]   stat_misses,
  output logic [15:0]   stat_evicts
`endif
);

  localparam int unsigned CW = $clog2(NB_MEM + 1);

  typedef enum logic [2:0] {StIdle, StLookup, StCheck, StWrite, StResp} state_e;

  state_e          state_q, state_d;
  logic [7:0]      data_q;
  logic            alloc_q;
  logic [AW-1:0]   alloc_ptr_q, alloc_ptr_d;
  logic [CW-1:0]   used_cnt_q, used_cnt_d;
  logic            hit_q, hit_d;
  logic            evict_q, evict_d;
  logic [AW-1:0]   index_q, index_d;
  logic            full;

  assign full = (used_cnt_q == CW'(NB_MEM));

  always_comb begin
    state_d     = state_q;
    alloc_ptr_d = alloc_ptr_q;
    used_cnt_d  = used_cnt_q;
    hit_d       = hit_q;
    evict_d     = evict_q;
    index_d     = index_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_hit     = 1'b0;
    rsp_index   = '0;
    rsp_evict   = 1'b0;
    cam_enable  = 1'b0;
    cam_write   = 1'b0;
    cam_addr    = '0;
    cam_data    = '0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) state_d = StLookup;
      end
      StLookup: begin
        cam_enable = 1'b1;
        cam_data   = data_q;
        state_d    = StCheck;
      end
      StCheck: begin
        // cam_found/cam_out were registered by the CAM on the lookup edge
        if (cam_found) begin
          hit_d   = 1'b1;
          index_d = cam_out;
          evict_d = 1'b0;
          state_d = StResp;
        end else if (!alloc_q) begin
          hit_d   = 1'b0;
          index_d = '0;
          evict_d = 1'b0;
          state_d = StResp;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        cam_write   = 1'b1;
        cam_addr    = alloc_ptr_q;
        cam_data    = data_q;
        hit_d       = 1'b0;
        index_d     = alloc_ptr_q;
        evict_d     = full;
        if (!full) used_cnt_d = used_cnt_q + CW'(1);
        alloc_ptr_d = (alloc_ptr_q == AW'(NB_MEM - 1)) ? '0 : alloc_ptr_q + AW'(1);
        state_d     = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        rsp_hit   = hit_q;
        rsp_index = index_q;
        rsp_evict = evict_q;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      alloc_q     <= 1'b0;
      alloc_ptr_q <= '0;
      used_cnt_q  <= '0;
      hit_q       <= 1'b0;
      evict_q     <= 1'b0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      alloc_ptr_q <= alloc_ptr_d;
      used_cnt_q  <= used_cnt_d;
      hit_q       <= hit_d;
      evict_q     <= evict_d;
      index_q     <= index_d;
      if (state_q == StIdle && req_valid) begin
        data_q  <= req_data;
        alloc_q <= req_alloc;
      end
    end
  end

`ifdef CAM_CTRL_STATS_EN
  logic rsp_done;
  assign rsp_done = (state_q == StResp) && rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_evicts <= '0;
    end else if (rsp_done) begin
      if (hit_q && stat_hits != 16'hFFFF) stat_hits <= stat_hits + 16'd1;
      if (!hit_q && stat_misses != 16'hFFFF) stat_misses <= stat_misses + 16'd1;
      if (evict_q && stat_evicts != 16'hFFFF) stat_evicts <= stat_evicts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// Self-checking bench for cam_ctrl: behavioural CAM, table vectors, corner sequences, random.
module tb_cam_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_alloc;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_ready, rsp_hit, rsp_evict;
  logic [4:0] rsp_index;
  logic       cam_enable, cam_write;
  logic [4:0] cam_addr;
  logic [7:0] cam_data;
  logic [4:0] cam_out;
  logic       cam_found;
`ifdef CAM_CTRL_STATS_EN
  logic [15:0] stat_hits, stat_misses, stat_evicts;
`endif

  always #5 clk = ~clk;

  cam_ctrl #(.NB_MEM(16), .AW(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_alloc  (req_alloc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_hit    (rsp_hit),
    .rsp_index  (rsp_index),
    .rsp_evict  (rsp_evict),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found)
`ifdef CAM_CTRL_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
    .stat_evicts(stat_evicts)
`endif
  );

  // Behavioural CAM: registered lowest-index match on cam_enable
  logic [7:0] cam_mem[32];
  bit         cam_vld[32];
  logic       cam_clear;

  always @(posedge clk) begin
    if (cam_clear) begin
      for (int i = 0; i < 32; i++) cam_vld[i] <= 1'b0;
      cam_found <= 1'b0;
      cam_out   <= '0;
    end else begin
      if (cam_write) begin
        cam_mem[cam_addr] <= cam_data;
        cam_vld[cam_addr] <= 1'b1;
      end
      if (cam_enable) begin
        cam_found <= 1'b0;
        cam_out   <= '0;
        for (int i = 31; i >= 0; i--)
          if (cam_vld[i] && cam_mem[i] == cam_data) begin
            cam_found <= 1'b1;
            cam_out   <= i[4:0];
          end
      end
    end
  end

  // Reference model: stored keys, round-robin pointer, occupancy
  logic [7:0] m_key[16];
  bit         m_vld[16];
  int         m_ptr, m_used;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_vld[i] = 1'b0;
    m_ptr  = 0;
    m_used = 0;
  endtask

  // Leaves the bench at a negedge with DUT and CAM cleared
  task automatic do_reset();
    rst_n     = 1'b0;
    cam_clear = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    cam_clear = 1'b0;
    model_reset();
  endtask

  // One full request/response; called and returns at a negedge
  task automatic txn(input logic [7:0] d, input logic a, input int hold,
                     output logic o_hit, output logic [4:0] o_idx, output logic o_ev);
    logic       e_hit, e_ev;
    logic [4:0] e_idx;
    int         e_lat, hit_i, en_cyc, wr_cyc, lat;
    logic [7:0] en_data, wr_data;
    logic [4:0] wr_addr;
    bit         strobe_ok, hold_ok;

    hit_i = -1;
    for (int i = 15; i >= 0; i--) if (m_vld[i] && m_key[i] == d) hit_i = i;
    if (hit_i >= 0) begin
      e_hit = 1'b1; e_idx = 5'(hit_i); e_ev = 1'b0; e_lat = 3;
    end else if (!a) begin
      e_hit = 1'b0; e_idx = '0; e_ev = 1'b0; e_lat = 3;
    end else begin
      e_hit = 1'b0; e_idx = 5'(m_ptr); e_ev = (m_used == 16); e_lat = 4;
      m_key[m_ptr] = d;
      m_vld[m_ptr] = 1'b1;
      m_ptr = (m_ptr + 1) % 16;
      if (m_used < 16) m_used++;
    end

    check("req_ready_idle", req_ready, 1'b1);
    rsp_ready = (hold == 0);
    req_valid = 1'b1;
    req_data  = d;
    req_alloc = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_data  = 8'($urandom);
    req_alloc = 1'($urandom);

    en_cyc = -1; wr_cyc = -1; lat = -1; strobe_ok = 1'b1;
    en_data = '0; wr_data = '0; wr_addr = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cam_enable && cam_write) strobe_ok = 1'b0;
      if (!cam_enable && !cam_write && (cam_data != 0 || cam_addr != 0)) strobe_ok = 1'b0;
      if (req_ready) strobe_ok = 1'b0;
      if (cam_enable) begin
        if (en_cyc < 0) begin en_cyc = k; en_data = cam_data; end
        else strobe_ok = 1'b0;
      end
      if (cam_write) begin
        if (wr_cyc >= 0) strobe_ok = 1'b0;
        wr_cyc = k; wr_addr = cam_addr; wr_data = cam_data;
      end
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    o_hit = rsp_hit; o_idx = rsp_index; o_ev = rsp_evict;

    check("latency", lat, e_lat);
    check("enable_cycle", en_cyc, 1);
    check("enable_data", en_data, d);
    if (a && !e_hit) begin
      check("write_cycle", wr_cyc, 3);
      check("write_addr", wr_addr, e_idx);
      check("write_data", wr_data, d);
    end else begin
      check("no_write", wr_cyc, -1);
    end
    check("strobe_rules", strobe_ok, 1'b1);
    check("rsp_hit", o_hit, e_hit);
    check("rsp_index", o_idx, e_idx);
    check("rsp_evict", o_ev, e_ev);

    if (hold > 0) begin
      hold_ok = 1'b1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_hit !== o_hit || rsp_index !== o_idx || rsp_evict !== o_ev)
          hold_ok = 1'b0;
        if (req_ready || cam_enable || cam_write) hold_ok = 1'b0;
      end
      check("rsp_hold_stable", hold_ok, 1'b1);
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    check("idle_after_rsp", {rsp_valid, req_ready}, 2'b01);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       alloc;
    int         hold;
    logic       hit;
    logic [4:0] index;
    logic       evict;
  } vec_t;

  vec_t       vecs[6];
  logic       r_hit, r_ev;
  logic [4:0] r_idx;
  int         wr_seen;
  bit         stray_rsp;

  initial begin
    vecs[0] = '{data: 8'h5A, alloc: 1'b1, hold: 0, hit: 1'b0, index: 5'd0, evict: 1'b0};
    vecs[1] = '{data: 8'h5A, alloc: 1'b1, hold: 0, hit: 1'b1, index: 5'd0, evict: 1'b0};
    vecs[2] = '{data: 8'h33, alloc: 1'b0, hold: 0, hit: 1'b0, index: 5'd0, evict: 1'b0};
    vecs[3] = '{data: 8'h77, alloc: 1'b1, hold: 5, hit: 1'b0, index: 5'd1, evict: 1'b0};
    vecs[4] = '{data: 8'h5A, alloc: 1'b0, hold: 0, hit: 1'b1, index: 5'd0, evict: 1'b0};
    vecs[5] = '{data: 8'h77, alloc: 1'b0, hold: 2, hit: 1'b1, index: 5'd1, evict: 1'b0};

    req_valid = 1'b0; req_data = '0; req_alloc = 1'b0; rsp_ready = 1'b1;
    rst_n = 1'b0; cam_clear = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_outputs",
          {rsp_valid, rsp_hit, rsp_index, rsp_evict, cam_enable, cam_write, cam_addr, cam_data},
          '0);
    rst_n = 1'b1; cam_clear = 1'b0;
    model_reset();

    for (int i = 0; i < 6; i++) begin
      txn(vecs[i].data, vecs[i].alloc, vecs[i].hold, r_hit, r_idx, r_ev);
      check("vec_hit", r_hit, vecs[i].hit);
      check("vec_index", r_idx, vecs[i].index);
      check("vec_evict", r_ev, vecs[i].evict);
    end

    // Fill all slots, check index-0 hit, then wrap-around eviction
    do_reset();
    for (int b = 0; b < 16; b++) txn(8'(b), 1'b1, 0, r_hit, r_idx, r_ev);
    txn(8'h00, 1'b0, 0, r_hit, r_idx, r_ev);
    check("idx0_hit", {r_hit, r_idx}, {1'b1, 5'd0});
    txn(8'h80, 1'b1, 0, r_hit, r_idx, r_ev);
    check("wrap_evict0", {r_hit, r_idx, r_ev}, {1'b0, 5'd0, 1'b1});
    txn(8'h81, 1'b1, 0, r_hit, r_idx, r_ev);
    check("wrap_evict1", {r_hit, r_idx, r_ev}, {1'b0, 5'd1, 1'b1});

    // Reset while the write strobe is up
    do_reset();
    req_valid = 1'b1; req_data = 8'h22; req_alloc = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wr_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cam_write) begin wr_seen = 1; break; end
    end
    check("reach_write", wr_seen, 1);
    rst_n = 1'b0; cam_clear = 1'b1;
    @(negedge clk);
    check("midreset_outputs",
          {rsp_valid, rsp_hit, rsp_index, rsp_evict, cam_enable, cam_write, cam_addr, cam_data},
          '0);
    check("midreset_ready", req_ready, 1'b1);
    rst_n = 1'b1; cam_clear = 1'b0;
    model_reset();
    stray_rsp = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) stray_rsp = 1'b1;
    end
    check("no_rsp_after_reset", stray_rsp, 1'b0);
    txn(8'h11, 1'b1, 0, r_hit, r_idx, r_ev);
    check("post_reset_alloc", {r_hit, r_idx, r_ev}, {1'b0, 5'd0, 1'b0});

    // Randomized traffic over a small key space to mix hits, misses and evictions
    for (int n = 0; n < 300; n++)
      txn(8'($urandom_range(0, 23)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
          r_hit, r_idx, r_ev);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
